ft_nmr_voter: RTL and testbench
===============================

// Module: ft_nmr_voter
// PURPOSE
// - N-modular redundancy voter: compares NUM_CH core results, forwards the majority value and detects faulty channels.
// - Drives per-channel recovery resets, then resynchronises each recovered channel before it is trusted again.
// - Sits between the redundant cores and the writeback/commit path of the fault-tolerant system.
// PARAMETERS
// WIDTH         32  result/data width in bits
// NUM_CH        3   redundant channels, >=2; NUM_CH=2 gives detection only, never correction
// RESET_CYCLES  8   cycles core_reset is held for a recovering channel, >=1
// SYNC_TIMEOUT  64  cycles allowed for a recovered channel to match the vote again
// MAX_RETRY     2   recovery attempts per channel before it is masked permanently
// CNT_W         16  width of error_count
// PORTS
// clk            in   1             clock, rising edge
// reset          in   1             synchronous, active-high
// valid          in   1             all result[] lanes carry a result this cycle
// result         in   NUM_CH*WIDTH  lane i = result[i*WIDTH +: WIDTH]
// data           out  WIDTH         voted result, registered
// data_valid     out  1             one-cycle pulse, data is good
// signal         out  1             one-cycle pulse, a mismatch was seen on the previous valid
// core_reset     out  NUM_CH        per-channel recovery reset to the cores
// fault_mask     out  NUM_CH        channel is excluded from voting
// dead_mask      out  NUM_CH        channel permanently excluded (retries exhausted)
// fatal          out  1             sticky: no majority; cleared only by reset
// error_count    out  CNT_W         saturating count of mismatch events
// BEHAVIOUR
// - Reset: data=0, data_valid=0, signal=0, core_reset=0, fault_mask=0, dead_mask=0, fatal=0, error_count=0.
//   State goes to MONITOR. All retry, hold and timeout counters go to 0.
// - Active set A = channels not in fault_mask. Agreement count of lane i = number of lanes in A equal to lane i.
// - Winner = lowest-index lane in A with 2*count > |A|. Lanes in A that differ from the winner are the new faulty set F.
// - Latency: on a cycle with valid=1, all outputs update on the next edge. There is no valid/ready backpressure.
//   Inputs are ignored while valid=0.
// - Winner exists: data <= winner and data_valid <= 1.
// - F != 0 on a valid cycle:
//   - signal <= 1 and error_count += 1; error_count saturates at all-ones.
//   - fault_mask |= F, core_reset[F] <= 1, retry[F] += 1.
//   - State -> RECOVER and the hold counter loads RESET_CYCLES.
// - No winner on a valid cycle (includes any mismatch when |A|=2, or all lanes masked):
//   - fatal <= 1, data_valid stays 0, error_count += 1, core_reset <= all ones.
//   - State -> FATAL. Stays in FATAL until reset.
// - RECOVER: core_reset stays asserted for masked, non-dead channels for exactly RESET_CYCLES cycles.
//   Then it drops to 0 and the state moves to SYNC with the timeout counter = 0.
// - SYNC: on each valid cycle with a winner, every masked, non-dead lane equal to the winner is unmasked.
//   Its retry counter clears. When no such lanes remain -> MONITOR.
// - SYNC timeout: after SYNC_TIMEOUT cycles without full resync, each still-masked lane is handled by its retry count:
//   - retry < MAX_RETRY: re-enter RECOVER with retry += 1.
//   - retry = MAX_RETRY: set its dead_mask bit (it stays in fault_mask) and it is never reset again.
// - A new fault during RECOVER/SYNC is allowed while a majority of A still exists:
//   - the new lanes join fault_mask;
//   - the state goes to RECOVER and the hold counter reloads, so the whole masked set is reset again.
// - Voting continues in RECOVER/SYNC. data_valid is produced whenever a winner exists.
// - Precedence on one edge: reset > fatal > new fault > timeout > resync.
// STRUCTURE
// - ft_pkg:
//   - ft_state_e {MONITOR, RECOVER, SYNC, FATAL};
//   - function popcount for the agreement counts.
// - Sub-module ft_majority_vote (combinational):
//   - inputs: result, active mask;
//   - outputs: winner, winner_ok, disagree mask.
// - Top holds the FSM, masks, the per-channel retry counters and the hold/timeout counter.
// TESTING
// - NUM_CH=3, all lanes 0x1234 with valid -> next cycle data=0x1234, data_valid=1, signal=0, core_reset=0.
// - Lanes {5,5,9}, lane2 wrong:
//   - data=5, signal=1, fault_mask=3'b100, error_count=1;
//   - core_reset=3'b100 for exactly 8 cycles, then SYNC.
//   - Next valid with lanes {7,7,7} -> fault_mask=0, state MONITOR.
// - Lane2 never matches: after 64 cycles it returns to RECOVER.
//   - The second timeout sets dead_mask=3'b100, and core_reset stays 0 afterwards.
// - Lanes {1,2,3} -> fatal=1, data_valid=0, core_reset=3'b111; all outputs hold until reset=1, then clear.
// - Lane2 masked and lanes {4,6,x} arrive -> fatal. Separately, NUM_CH=2 with {1,2} -> fatal.
// - Force error_count to all-ones, then another mismatch -> error_count stays 0xFFFF.
// - reset=1 mid-RECOVER -> next cycle core_reset=0, masks=0, state MONITOR.

Source files
------------

// File: rtl/ft_pkg.sv
// ============================================================================
// Module      : ft_pkg
// Description : Shared state encoding and helpers for the NMR voter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ft_pkg;

    typedef enum logic [1:0] {
        MONITOR = 2'd0,
        RECOVER = 2'd1,
        SYNC    = 2'd2,
        FATAL   = 2'd3
    } ft_state_e;

    // Widest channel vector the helpers accept; callers zero-extend into it.
    localparam int c_max_ch = 32;

    function automatic int unsigned popcount(input logic [c_max_ch-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < c_max_ch; i++) begin
            if (v[i]) n++;
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ft_majority_vote.sv
// ============================================================================
// Module      : ft_majority_vote
// Description : Combinational strict-majority vote over the active lanes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ft_majority_vote
    import ft_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 3
) (
    input  logic [NUM_CH*WIDTH-1:0] result,
    input  logic [NUM_CH-1:0]       active,
    output logic [WIDTH-1:0]        winner,
    output logic                    winner_ok,
    output logic [NUM_CH-1:0]       disagree
);

    logic [NUM_CH-1:0] w_agree;
    int unsigned       w_n_active;

    // Lowest-index active lane agreeing with more than half of the active set wins.
    always_comb begin : p_vote
        winner     = '0;
        winner_ok  = 1'b0;
        disagree   = '0;
        w_agree    = '0;
        w_n_active = popcount(c_max_ch'(active));
        for (int i = 0; i < NUM_CH; i++) begin
            for (int j = 0; j < NUM_CH; j++) begin
                w_agree[j] = active[j] &&
                             (result[j*WIDTH +: WIDTH] == result[i*WIDTH +: WIDTH]);
            end
            if (active[i] && !winner_ok &&
                (2 * popcount(c_max_ch'(w_agree)) > w_n_active)) begin
                winner    = result[i*WIDTH +: WIDTH];
                winner_ok = 1'b1;
            end
        end
        for (int j = 0; j < NUM_CH; j++) begin
            disagree[j] = winner_ok && active[j] &&
                          (result[j*WIDTH +: WIDTH] != winner);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ft_nmr_voter.sv
// ============================================================================
// Module      : ft_nmr_voter
// Description : N-modular redundancy voter with per-channel recovery/resync.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ft_nmr_voter
    import ft_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int NUM_CH       = 3,
    parameter int RESET_CYCLES = 8,
    parameter int SYNC_TIMEOUT = 64,
    parameter int MAX_RETRY    = 2,
    parameter int CNT_W        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    valid,
    input  logic [NUM_CH*WIDTH-1:0] result,
    output logic [WIDTH-1:0]        data,
    output logic                    data_valid,
    output logic                    signal,
    output logic [NUM_CH-1:0]       core_reset,
    output logic [NUM_CH-1:0]       fault_mask,
    output logic [NUM_CH-1:0]       dead_mask,
    output logic                    fatal,
    output logic [CNT_W-1:0]        error_count
);

    localparam int c_tmr_max = (RESET_CYCLES > SYNC_TIMEOUT) ? RESET_CYCLES : SYNC_TIMEOUT;
    localparam int c_tmr_w   = $clog2(c_tmr_max + 1);
    localparam int c_retry_w = $clog2(MAX_RETRY + 2);

    localparam logic [c_tmr_w-1:0]   c_hold_load    = c_tmr_w'(RESET_CYCLES);
    localparam logic [c_tmr_w-1:0]   c_timeout_last = c_tmr_w'(SYNC_TIMEOUT - 1);
    localparam logic [c_retry_w-1:0] c_retry_max    = c_retry_w'(MAX_RETRY);

    ft_state_e              r_state, w_state_nxt;
    logic [WIDTH-1:0]       r_data, w_data_nxt;
    logic                   r_dv, w_dv_nxt;
    logic                   r_sig, w_sig_nxt;
    logic [NUM_CH-1:0]      r_core_reset, w_cr_nxt;
    logic [NUM_CH-1:0]      r_fault_mask, w_fm_nxt;
    logic [NUM_CH-1:0]      r_dead_mask, w_dm_nxt;
    logic                   r_fatal, w_fatal_nxt;
    logic [CNT_W-1:0]       r_err, w_err_nxt, w_err_inc;
    logic [c_tmr_w-1:0]     r_tmr, w_tmr_nxt;
    logic [c_retry_w-1:0]   r_retry     [NUM_CH];
    logic [c_retry_w-1:0]   w_retry_nxt [NUM_CH];

    logic [WIDTH-1:0]       w_winner;
    logic                   w_win_ok;
    logic [NUM_CH-1:0]      w_disagree;
    logic [NUM_CH-1:0]      w_match;
    logic [NUM_CH-1:0]      w_recovering;
    logic [NUM_CH-1:0]      w_requeue;

    ft_majority_vote #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH)
    ) u_vote (
        .result    (result),
        .active    (~r_fault_mask),
        .winner    (w_winner),
        .winner_ok (w_win_ok),
        .disagree  (w_disagree)
    );

    // Masked lanes are compared too, so a recovered channel can be readmitted.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_match
        assign w_match[gi] = (result[gi*WIDTH +: WIDTH] == w_winner);
    end

    assign w_recovering = r_fault_mask & ~r_dead_mask;
    assign w_err_inc    = (&r_err) ? r_err : r_err + CNT_W'(1);

    always_comb begin : p_next
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_dv_nxt    = 1'b0;
        w_sig_nxt   = 1'b0;
        w_cr_nxt    = r_core_reset;
        w_fm_nxt    = r_fault_mask;
        w_dm_nxt    = r_dead_mask;
        w_fatal_nxt = r_fatal;
        w_err_nxt   = r_err;
        w_tmr_nxt   = r_tmr;
        w_retry_nxt = r_retry;
        w_requeue   = '0;

        if (r_state != FATAL) begin
            if (valid && !w_win_ok) begin
                w_state_nxt = FATAL;
                w_fatal_nxt = 1'b1;
                w_cr_nxt    = '1;
                w_err_nxt   = w_err_inc;
            end else begin
                if (valid) begin
                    w_data_nxt = w_winner;
                    w_dv_nxt   = 1'b1;
                end
                if (valid && (|w_disagree)) begin
                    // Whole masked set is reset again when a new lane drops out.
                    w_sig_nxt   = 1'b1;
                    w_err_nxt   = w_err_inc;
                    w_fm_nxt    = r_fault_mask | w_disagree;
                    w_cr_nxt    = w_fm_nxt & ~r_dead_mask;
                    w_state_nxt = RECOVER;
                    w_tmr_nxt   = c_hold_load;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (w_disagree[i]) w_retry_nxt[i] = r_retry[i] + c_retry_w'(1);
                    end
                end else if (r_state == RECOVER) begin
                    if (r_tmr <= c_tmr_w'(1)) begin
                        w_state_nxt = SYNC;
                        w_cr_nxt    = '0;
                        w_tmr_nxt   = '0;
                    end else begin
                        w_tmr_nxt = r_tmr - c_tmr_w'(1);
                    end
                end else if (r_state == SYNC) begin
                    if (r_tmr >= c_timeout_last) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            if (w_recovering[i]) begin
                                if (r_retry[i] >= c_retry_max) begin
                                    w_dm_nxt[i] = 1'b1;
                                end else begin
                                    w_retry_nxt[i] = r_retry[i] + c_retry_w'(1);
                                    w_requeue[i]   = 1'b1;
                                end
                            end
                        end
                        if (|w_requeue) begin
                            w_state_nxt = RECOVER;
                            w_tmr_nxt   = c_hold_load;
                            w_cr_nxt    = w_requeue;
                        end else begin
                            w_state_nxt = MONITOR;
                            w_tmr_nxt   = '0;
                            w_cr_nxt    = '0;
                        end
                    end else begin
                        w_tmr_nxt = r_tmr + c_tmr_w'(1);
                        if (valid) begin
                            w_fm_nxt = r_fault_mask & ~(w_recovering & w_match);
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (w_recovering[i] && w_match[i]) w_retry_nxt[i] = '0;
                            end
                            if ((w_recovering & ~w_match) == '0) begin
                                w_state_nxt = MONITOR;
                                w_tmr_nxt   = '0;
                            end
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin : p_regs
        if (reset) begin
            r_state      <= MONITOR;
            r_data       <= '0;
            r_dv         <= 1'b0;
            r_sig        <= 1'b0;
            r_core_reset <= '0;
            r_fault_mask <= '0;
            r_dead_mask  <= '0;
            r_fatal      <= 1'b0;
            r_err        <= '0;
            r_tmr        <= '0;
            for (int i = 0; i < NUM_CH; i++) r_retry[i] <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_data       <= w_data_nxt;
            r_dv         <= w_dv_nxt;
            r_sig        <= w_sig_nxt;
            r_core_reset <= w_cr_nxt;
            r_fault_mask <= w_fm_nxt;
            r_dead_mask  <= w_dm_nxt;
            r_fatal      <= w_fatal_nxt;
            r_err        <= w_err_nxt;
            r_tmr        <= w_tmr_nxt;
            r_retry      <= w_retry_nxt;
        end
    end

    assign data        = r_data;
    assign data_valid  = r_dv;
    assign signal      = r_sig;
    assign core_reset  = r_core_reset;
    assign fault_mask  = r_fault_mask;
    assign dead_mask   = r_dead_mask;
    assign fatal       = r_fatal;
    assign error_count = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ft_nmr_voter.sv
// ============================================================================
// Module      : tb_ft_nmr_voter
// Description : Scoreboard bench for ft_nmr_voter (3-lane) plus a 2-lane sanity run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ft_nmr_voter;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int RC = 8;
    localparam int ST = 64;
    localparam int MR = 2;
    localparam int CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset  = 1'b1;
    logic           valid  = 1'b0;
    logic [N*W-1:0] result = '0;
    logic [W-1:0]   data;
    logic           data_valid, signal, fatal;
    logic [N-1:0]   core_reset, fault_mask, dead_mask;
    logic [CW-1:0]  error_count;

    ft_nmr_voter #(
        .WIDTH(W), .NUM_CH(N), .RESET_CYCLES(RC), .SYNC_TIMEOUT(ST),
        .MAX_RETRY(MR), .CNT_W(CW)
    ) u_dut (
        .clk(clk), .reset(reset), .valid(valid), .result(result),
        .data(data), .data_valid(data_valid), .signal(signal),
        .core_reset(core_reset), .fault_mask(fault_mask), .dead_mask(dead_mask),
        .fatal(fatal), .error_count(error_count)
    );

    logic        reset2  = 1'b1;
    logic        valid2  = 1'b0;
    logic [15:0] result2 = '0;
    logic [7:0]  data2;
    logic        data_valid2, signal2, fatal2;
    logic [1:0]  core_reset2, fault_mask2, dead_mask2;
    logic [15:0] error_count2;
    bit          done2 = 1'b0;

    ft_nmr_voter #(
        .WIDTH(8), .NUM_CH(2), .RESET_CYCLES(RC), .SYNC_TIMEOUT(ST),
        .MAX_RETRY(MR), .CNT_W(16)
    ) u_dut2 (
        .clk(clk), .reset(reset2), .valid(valid2), .result(result2),
        .data(data2), .data_valid(data_valid2), .signal(signal2),
        .core_reset(core_reset2), .fault_mask(fault_mask2), .dead_mask(dead_mask2),
        .fatal(fatal2), .error_count(error_count2)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: the voter described as rules over lane values.
    typedef enum int {S_WATCH, S_HOLD, S_RESYNC, S_HALT} mode_t;

    typedef struct {
        logic [W-1:0]  data;
        logic          dv, sig, sig_chk, fatal;
        logic [N-1:0]  cr, fm, dm;
        logic [CW-1:0] err;
    } exp_t;

    exp_t          q[$];
    mode_t         m_mode = S_WATCH;
    logic [W-1:0]  m_data = '0;
    logic          m_dv = 1'b0, m_sig = 1'b0, m_fatal = 1'b0;
    logic [N-1:0]  m_cr = '0, m_fm = '0, m_dm = '0;
    logic [CW-1:0] m_err = '0;
    int            m_retry [N];
    int            m_hold_left = 0, m_elapsed = 0;

    task automatic bump_err();
        if (m_err != '1) m_err = m_err + CW'(1);
    endtask

    task automatic start_recover();
        m_mode      = S_HOLD;
        m_hold_left = RC;
        m_cr        = m_fm & ~m_dm;
    endtask

    task automatic model_step(input bit rst, input bit v, input logic [W-1:0] ln [N]);
        exp_t         e;
        int           na, win, c;
        bit           any, sig_chk;
        logic [N-1:0] f;
        m_dv = 1'b0; m_sig = 1'b0; sig_chk = 1'b1;
        if (rst) begin
            m_mode = S_WATCH; m_data = '0; m_cr = '0; m_fm = '0; m_dm = '0;
            m_fatal = 1'b0; m_err = '0; m_hold_left = 0; m_elapsed = 0;
            for (int i = 0; i < N; i++) m_retry[i] = 0;
        end else if (m_mode != S_HALT) begin
            na = 0; win = -1; f = '0;
            for (int i = 0; i < N; i++) if (!m_fm[i]) na++;
            for (int i = 0; i < N; i++) begin
                if (!m_fm[i] && win < 0) begin
                    c = 0;
                    for (int j = 0; j < N; j++) if (!m_fm[j] && ln[j] == ln[i]) c++;
                    if (2 * c > na) win = i;
                end
            end
            if (v && win < 0) begin
                m_mode = S_HALT; m_fatal = 1'b1; m_cr = '1; bump_err();
                sig_chk = 1'b0;
            end else begin
                if (v) begin
                    m_data = ln[win]; m_dv = 1'b1;
                    for (int i = 0; i < N; i++) if (!m_fm[i] && ln[i] != ln[win]) f[i] = 1'b1;
                end
                if (f != '0) begin
                    m_sig = 1'b1; bump_err();
                    m_fm = m_fm | f;
                    for (int i = 0; i < N; i++) if (f[i]) m_retry[i]++;
                    start_recover();
                end else if (m_mode == S_HOLD) begin
                    m_hold_left--;
                    if (m_hold_left == 0) begin
                        m_cr = '0; m_mode = S_RESYNC; m_elapsed = 0;
                    end
                end else if (m_mode == S_RESYNC) begin
                    m_elapsed++;
                    if (m_elapsed == ST) begin
                        any = 1'b0;
                        for (int i = 0; i < N; i++) begin
                            if (m_fm[i] && !m_dm[i]) begin
                                if (m_retry[i] >= MR) m_dm[i] = 1'b1;
                                else begin m_retry[i]++; any = 1'b1; end
                            end
                        end
                        if (any) start_recover();
                        else begin m_mode = S_WATCH; m_cr = '0; end
                    end else if (v) begin
                        for (int i = 0; i < N; i++) begin
                            if (m_fm[i] && !m_dm[i] && ln[i] == ln[win]) begin
                                m_fm[i] = 1'b0; m_retry[i] = 0;
                            end
                        end
                        if ((m_fm & ~m_dm) == '0) m_mode = S_WATCH;
                    end
                end
            end
        end
        e.data = m_data; e.dv = m_dv; e.sig = m_sig; e.sig_chk = sig_chk; e.fatal = m_fatal;
        e.cr = m_cr; e.fm = m_fm; e.dm = m_dm; e.err = m_err;
        q.push_back(e);
    endtask

    task automatic cyc(input bit rst, input bit v, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] c);
        logic [W-1:0] ln [N];
        @(negedge clk);
        reset = rst; valid = v; result = {c, b, a};
        ln[0] = a; ln[1] = b; ln[2] = c;
        model_step(rst, v, ln);
    endtask

    initial begin : p_monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("data",        64'(data),        64'(e.data));
                check("data_valid",  64'(data_valid),  64'(e.dv));
                if (e.sig_chk) check("signal", 64'(signal), 64'(e.sig));
                check("fatal",       64'(fatal),       64'(e.fatal));
                check("core_reset",  64'(core_reset),  64'(e.cr));
                check("fault_mask",  64'(fault_mask),  64'(e.fm));
                check("dead_mask",   64'(dead_mask),   64'(e.dm));
                check("error_count", 64'(error_count), 64'(e.err));
            end
        end
    end

    initial begin : p_dut2
        @(negedge clk);
        reset2 = 1'b0;
        check("n2_reset_data",  64'(data2),       64'(0));
        check("n2_reset_fatal", 64'(fatal2),      64'(0));
        check("n2_reset_cr",    64'(core_reset2), 64'(0));
        check("n2_reset_masks", 64'({fault_mask2, dead_mask2}), 64'(0));
        valid2 = 1'b1; result2 = {8'd3, 8'd3};
        @(posedge clk); #2;
        check("n2_agree_data",  64'(data2),       64'(3));
        check("n2_agree_dv",    64'(data_valid2), 64'(1));
        check("n2_agree_sig",   64'(signal2),     64'(0));
        @(negedge clk);
        result2 = {8'd2, 8'd1};
        @(posedge clk); #2;
        check("n2_split_fatal", 64'(fatal2),       64'(1));
        check("n2_split_dv",    64'(data_valid2),  64'(0));
        check("n2_split_cr",    64'(core_reset2),  64'(2'b11));
        check("n2_split_err",   64'(error_count2), 64'(1));
        @(negedge clk);
        result2 = {8'd5, 8'd5};
        @(posedge clk); #2;
        check("n2_hold_fatal",  64'(fatal2),      64'(1));
        check("n2_hold_dv",     64'(data_valid2), 64'(0));
        check("n2_hold_data",   64'(data2),       64'(3));
        @(negedge clk);
        reset2 = 1'b1; valid2 = 1'b0;
        @(posedge clk); #2;
        check("n2_clr_fatal",   64'(fatal2),       64'(0));
        check("n2_clr_cr",      64'(core_reset2),  64'(0));
        check("n2_clr_err",     64'(error_count2), 64'(0));
        done2 = 1'b1;
    end

    initial begin : p_stim
        logic [W-1:0] x, y;
        logic [W-1:0] l [N];
        int           bad;
        for (int i = 0; i < N; i++) m_retry[i] = 0;

        cyc(1'b1, 1'b0, '0, '0, '0);
        cyc(1'b1, 1'b0, '0, '0, '0);
        cyc(1'b0, 1'b1, 32'h1234, 32'h1234, 32'h1234);
        repeat (20) begin
            x = $urandom;
            cyc(1'b0, $urandom_range(0, 1) != 0, x, x, x);
        end

        // Single wrong lane, recovery, then resync on an agreeing result.
        cyc(1'b0, 1'b1, 32'd5, 32'd5, 32'd9);
        repeat (RC) begin
            x = $urandom;
            cyc(1'b0, 1'b1, x, x, $urandom);
        end
        cyc(1'b0, 1'b1, 32'd7, 32'd7, 32'd7);

        // Lane 2 never comes back: two timeouts leave it dead.
        cyc(1'b0, 1'b1, 32'd3, 32'd3, 32'd4);
        repeat (2 * (RC + ST) + 12) begin
            x = $urandom;
            cyc(1'b0, $urandom_range(0, 1) != 0, x, x, ~x);
        end
        cyc(1'b1, 1'b0, '0, '0, '0);

        // Repeated fault/recover rounds drive the counter into saturation.
        repeat (18) begin
            x = $urandom; y = $urandom;
            bad = $urandom_range(0, N - 1);
            for (int i = 0; i < N; i++) l[i] = x;
            l[bad] = ~x;
            cyc(1'b0, 1'b1, l[0], l[1], l[2]);
            repeat (RC) cyc(1'b0, 1'b0, '0, '0, '0);
            cyc(1'b0, 1'b1, y, y, y);
        end
        cyc(1'b1, 1'b0, '0, '0, '0);

        // Three-way split is fatal and everything holds until reset.
        cyc(1'b0, 1'b1, 32'd1, 32'd2, 32'd3);
        repeat (5) cyc(1'b0, 1'b1, 32'd6, 32'd6, 32'd6);
        cyc(1'b1, 1'b0, '0, '0, '0);
        cyc(1'b0, 1'b0, '0, '0, '0);

        // With lane 2 masked, any disagreement between the remaining two is fatal.
        cyc(1'b0, 1'b1, 32'd8, 32'd8, 32'd9);
        cyc(1'b0, 1'b1, 32'd4, 32'd6, $urandom);
        repeat (3) cyc(1'b0, 1'b1, $urandom, $urandom, $urandom);
        cyc(1'b1, 1'b0, '0, '0, '0);

        // Reset in the middle of a recovery hold.
        cyc(1'b0, 1'b1, 32'd2, 32'd7, 32'd7);
        repeat (3) cyc(1'b0, 1'b1, 32'd7, 32'd7, 32'd7);
        cyc(1'b1, 1'b0, '0, '0, '0);
        cyc(1'b0, 1'b1, 32'd11, 32'd11, 32'd11);

        // Random soak with small values so accidental agreement happens.
        repeat (1500) begin
            if (m_mode == S_HALT && $urandom_range(0, 3) == 0) begin
                cyc(1'b1, 1'b0, '0, '0, '0);
            end else begin
                x = W'($urandom_range(0, 3));
                for (int i = 0; i < N; i++) l[i] = x;
                if ($urandom_range(0, 7) == 0) l[$urandom_range(0, N - 1)] = W'($urandom_range(0, 3));
                if ($urandom_range(0, 39) == 0) l[$urandom_range(0, N - 1)] = $urandom;
                cyc(1'b0, $urandom_range(0, 3) != 0, l[0], l[1], l[2]);
            end
        end

        for (int k = 0; k < 10 && q.size() != 0; k++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        for (int k = 0; k < 100 && !done2; k++) @(posedge clk);
        if (!done2) begin
            n_total++;
            $display("FAIL n2_done: got 0, expected 1");
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
